// File: rtl/uart_pkg.sv
// Shared types for the buffered UART transmitter: serialiser states, byte width
// and the line-level decode used by the serialiser.
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_STOP
  } uart_state_e;

  function automatic logic line_level(uart_state_e st, logic data_bit);
    case (st)
      UART_START: return 1'b0;
      UART_DATA:  return data_bit;
      default:    return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_core.sv
// 8N1 serialiser: IDLE -> START -> DATA(8 bits, LSB first) -> STOP, one bit period each.
// The line is registered, so it lags the state register by one cycle.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int CLK_PER_HALF_BIT = 434
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic [7:0] byte_in,
  output logic       idle,
  output logic       UART_TX
);

  localparam int BIT_CYC = 2 * CLK_PER_HALF_BIT;
  localparam int TMR_W   = (BIT_CYC > 2) ? $clog2(BIT_CYC) : 1;
  localparam logic [TMR_W-1:0] TMR_BIT  = TMR_W'(BIT_CYC - 1);
  // STOP is one cycle short: the mandatory IDLE cycle before the next START
  // supplies the final high cycle, keeping frames exactly 10 bit periods.
  localparam logic [TMR_W-1:0] TMR_STOP = TMR_W'(BIT_CYC - 2);

  uart_state_e      state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             tmr_done;

  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tmr_done = (tmr_q == '0);
    case (state_q)
      UART_IDLE: begin
        if (start) begin
          state_d = UART_START;
          tmr_d   = TMR_BIT;
          shift_d = byte_in;
        end
      end
      UART_START: begin
        if (tmr_done) begin
          state_d = UART_DATA;
          tmr_d   = TMR_BIT;
          bit_d   = '0;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      UART_DATA: begin
        if (tmr_done) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = UART_STOP;
            tmr_d   = TMR_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
            tmr_d = TMR_BIT;
          end
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      UART_STOP: begin
        if (tmr_done) begin
          state_d = UART_IDLE;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      default: state_d = UART_IDLE;
    endcase
    tx_d = line_level(state_q, shift_q[0]);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= UART_IDLE;
      tmr_q   <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign idle    = (state_q == UART_IDLE);
  assign UART_TX = tx_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO of word/byte entries plus an issue controller
// that feeds the head entry to the serialiser one byte at a time, little-endian.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W           = 32,
  parameter int DEPTH            = 128,
  parameter int CLK_PER_HALF_BIT = 434
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   valid,
  input  logic [DATA_W-1:0]      data,
  input  logic                   id,
  output logic                   ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   busy,
  output logic                   UART_TX
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int NBYTES = DATA_W / BYTE_W;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  // Entry layout depends on DATA_W, so the struct is declared per instance.
  typedef struct packed {
    logic              is_byte;
    logic [DATA_W-1:0] data;
  } fifo_entry_t;

  fifo_entry_t      mem_q [DEPTH];
  fifo_entry_t      head;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             idle_q;
  logic             push, issue, retire, last_byte, core_idle;
  logic [BYTE_W-1:0] tx_byte;

  assign head  = mem_q[rd_ptr_q];
  assign ready = (count_q != CNT_W'(DEPTH));

  always_comb begin
    push      = valid && ready;
    issue     = (count_q != '0) && core_idle;
    last_byte = head.is_byte || (idx_q == LAST_IDX);
    retire    = issue && last_byte;
    tx_byte   = head.data[idx_q*BYTE_W +: BYTE_W];

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    idx_d    = idx_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (issue) begin
      idx_d = last_byte ? '0 : idx_q + IDX_W'(1);
    end
    if (retire) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(retire);
    // idle_q covers the one-cycle lag of the registered line behind the FSM.
    busy_d  = (count_q != '0) || !core_idle || !idle_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      idle_q   <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      idle_q   <= core_idle;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{is_byte: id, data: data};
    end
  end

  uart_tx_core #(
    .CLK_PER_HALF_BIT(CLK_PER_HALF_BIT)
  ) u_core (
    .clk     (clk),
    .rstn    (rstn),
    .start   (issue),
    .byte_in (tx_byte),
    .idle    (core_idle),
    .UART_TX (UART_TX)
  );

  assign count = count_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: expected bytes queued on accepted pushes,
// a line receiver decodes 8N1 frames and compares them in order.
module tb_uart_tx_fifo;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int CPHB   = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        valid;
  logic [31:0] data;
  logic        id;
  logic        ready;
  logic [2:0]  count;
  logic        busy;
  logic        UART_TX;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .DATA_W(DATA_W),
    .DEPTH(DEPTH),
    .CLK_PER_HALF_BIT(CPHB)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .valid(valid),
    .data(data),
    .id(id),
    .ready(ready),
    .count(count),
    .busy(busy),
    .UART_TX(UART_TX)
  );

  int         n_chk = 0;
  int         n_pass = 0;
  int         rx_frames = 0;
  logic [7:0] sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] mkw(input int i);
    return {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
  endfunction

  // Called in the low clock phase; leaves valid asserted for back-to-back use.
  task automatic push(input logic [31:0] d, input logic is_b, input logic exp_acc);
    valid = 1'b1;
    data  = d;
    id    = is_b;
    check("push_ready", 32'(ready), 32'(exp_acc));
    if (exp_acc) begin
      if (is_b) sb.push_back(d[7:0]);
      else for (int b = 0; b < 4; b++) sb.push_back(d[8*b +: 8]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string tag);
    int i;
    for (i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) break;
    end
    check(tag, 32'(i < 4000), 1);
  endtask

  task automatic mon_wait(input int n, inout bit ok);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (rstn !== 1'b1) begin
        ok = 1'b0;
        break;
      end
    end
  endtask

  initial begin : monitor
    logic [7:0] rx;
    logic [7:0] exp_b;
    bit         ok;
    forever begin
      @(negedge clk);
      if (rstn === 1'b1 && UART_TX === 1'b0) begin
        ok = 1'b1;
        rx = '0;
        mon_wait(4, ok);
        if (ok) check("rx_start_bit", 32'(UART_TX), 0);
        for (int k = 0; k < 8; k++) begin
          if (ok) mon_wait(8, ok);
          if (ok) rx[k] = UART_TX;
        end
        if (ok) mon_wait(8, ok);
        if (ok) begin
          check("rx_stop_bit", 32'(UART_TX), 1);
          rx_frames++;
          if (sb.size() == 0) begin
            check("rx_unexpected_frame", 32'(rx), 32'h100);
          end else begin
            exp_b = sb.pop_front();
            check("rx_byte", 32'(rx), 32'(exp_b));
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog timeout");
  end

  initial begin
    int         f0;
    int         j;
    logic [9:0] a5_bits;
    a5_bits = 10'b11_0100_1010;
    valid = 1'b0;
    data  = '0;
    id    = 1'b0;
    rstn  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(UART_TX), 1);
    check("rst_count", 32'(count), 0);
    check("rst_ready", 32'(ready), 1);
    check("rst_busy", 32'(busy), 0);
    rstn = 1'b1;
    @(negedge clk);

    // 1: word, little-endian, latency and busy drop
    push(32'h44332211, 1'b0, 1'b1);
    valid = 1'b0;
    @(negedge clk);
    check("t1_count_n1", 32'(count), 1);
    check("t1_tx_n1", 32'(UART_TX), 1);
    check("t1_busy_n1", 32'(busy), 0);
    @(negedge clk);
    check("t1_tx_n2", 32'(UART_TX), 1);
    check("t1_busy_n2", 32'(busy), 1);
    check("t1_count_n2", 32'(count), 1);
    @(negedge clk);
    check("t1_start_latency", 32'(UART_TX), 0);
    repeat (319) @(negedge clk);
    check("t1_busy_before_end", 32'(busy), 1);
    @(negedge clk);
    check("t1_busy_after_end", 32'(busy), 0);
    wait_drain("t1_drain");
    check("t1_frames", 32'(rx_frames), 4);

    // 2: single byte, exact line bits
    f0 = rx_frames;
    @(negedge clk);
    push(32'h000000A5, 1'b1, 1'b1);
    valid = 1'b0;
    @(negedge clk);
    check("t2_count_pushed", 32'(count), 1);
    @(negedge clk);
    check("t2_count_handoff", 32'(count), 0);
    @(negedge clk);
    repeat (4) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      check("t2_line_bit", 32'(UART_TX), 32'(a5_bits[k]));
      repeat (8) @(negedge clk);
    end
    wait_drain("t2_drain");
    check("t2_frames", 32'(rx_frames - f0), 1);

    // 3: overflow drops the 5th and 6th words
    f0 = rx_frames;
    @(negedge clk);
    for (int i = 0; i < 6; i++) push(mkw(40 + i), 1'b0, i < 4);
    valid = 1'b0;
    @(negedge clk);
    check("t3_count_full", 32'(count), 4);
    check("t3_ready_full", 32'(ready), 0);
    wait_drain("t3_drain");
    check("t3_frames", 32'(rx_frames - f0), 16);

    // 4: push right after each retire while full; pointers wrap
    f0 = rx_frames;
    @(negedge clk);
    for (int i = 0; i < 4; i++) push(mkw(i), 1'b0, 1'b1);
    valid = 1'b0;
    @(negedge clk);
    check("t4_ready_full", 32'(ready), 0);
    for (int i = 4; i < 10; i++) begin
      for (j = 0; j < 400; j++) begin
        if (ready) break;
        @(negedge clk);
      end
      check("t4_count_freed", 32'(count), 3);
      push(mkw(i), 1'b0, 1'b1);
      valid = 1'b0;
      @(negedge clk);
      check("t4_count_refull", 32'(count), 4);
    end
    wait_drain("t4_drain");
    check("t4_frames", 32'(rx_frames - f0), 40);

    // 5: async reset mid-DATA of the second byte
    @(negedge clk);
    push(32'hCAFEF00D, 1'b0, 1'b1);
    valid = 1'b0;
    for (j = 0; j < 20; j++) begin
      @(negedge clk);
      if (UART_TX == 1'b0) break;
    end
    check("t5_start_seen", 32'(j < 20), 1);
    repeat (118) @(negedge clk);
    check("t5_tx_pre_reset", 32'(UART_TX), 0);
    rstn = 1'b0;
    #1;
    check("t5_rst_tx", 32'(UART_TX), 1);
    check("t5_rst_count", 32'(count), 0);
    check("t5_rst_ready", 32'(ready), 1);
    check("t5_rst_busy", 32'(busy), 0);
    repeat (2) @(negedge clk);
    sb.delete();
    rstn = 1'b1;
    @(negedge clk);
    f0 = rx_frames;
    push(32'h04030201, 1'b0, 1'b1);
    valid = 1'b0;
    wait_drain("t5_drain");
    check("t5_frames", 32'(rx_frames - f0), 4);

    // 6: word then byte interleaved
    f0 = rx_frames;
    @(negedge clk);
    push(32'hDEADBEEF, 1'b0, 1'b1);
    push(32'h0000007E, 1'b1, 1'b1);
    valid = 1'b0;
    wait_drain("t6_drain");
    check("t6_frames", 32'(rx_frames - f0), 5);
    check("final_sb_empty", 32'(sb.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
